// File: rtl/hw_alu_seq.sv
// Command sequencer for a 2-bit-select combinational ALU (add/sub/and/shr).
// It accepts one command at a time, drives registered ALU inputs from the
// accumulator and writes the ALU result back. The accumulator value is
// returned on a valid/ready response port.
module hw_alu_seq #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] alu_din0,
  output logic [WIDTH-1:0] alu_din1,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_dout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             err;

  // Sequencer FSM: accepts a command in IDLE, spends one cycle in EXEC for
  // ALU ops so the registered ALU inputs can settle, then holds RESP until
  // the consumer takes the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      err      <= 1'b0;
      alu_din0 <= '0;
      alu_din1 <= '0;
      alu_sel  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (!cmd_op[2]) begin
              alu_din0 <= acc;
              alu_din1 <= cmd_operand;
              alu_sel  <= cmd_op[1:0];
              state    <= EXEC;
            end else begin
              state <= RESP;
              case (cmd_op[1:0])
                2'b00: begin
                  acc <= cmd_operand;
                  err <= 1'b0;
                end
                2'b01: begin
                  acc <= '0;
                  err <= 1'b0;
                end
                default: err <= 1'b1;
              endcase
            end
          end
        end
        EXEC: begin
          acc   <= alu_dout;
          err   <= 1'b0;
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_data  = acc;
  assign rsp_zero  = (acc == '0);
  assign rsp_err   = err;

endmodule
